// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the CPU-side Avalon-MM memory master.
package mips_mem_pkg;

  // Access width requested by the load/store path.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } mem_size_t;

  // Bus master sequencing: wait for a request, run it on the bus, report it.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } mem_state_t;

  // True when a half/word access does not sit on its natural boundary.
  function automatic logic misaligned(input mem_size_t size, input logic [1:0] addr_lo);
    return ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mips_mem_lane_align.sv
// Byte-lane steering between the CPU's right-justified data and the 32-bit bus.
// Stores: lane enables and lane-replicated write data.
// Loads: pick the addressed lane(s) out of readdata and sign/zero-extend.
module mips_mem_lane_align
  import mips_mem_pkg::*;
(
  input  mem_size_t   size_i,
  input  logic [1:0]  offset_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign sel_byte = rdata_i[{offset_i, 3'b000} +: 8];
  assign sel_half = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Lane enables, replicated store data and extended load data per access size.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    be_o    = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & sel_byte[7]}}, sel_byte};
      end
      SZ_HALF: begin
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & sel_half[15]}}, sel_half};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_mem_master.sv
// Avalon-MM master for the CPU load/store path. One request in flight at a
// time: accept in IDLE, hold the bus in ACCESS until waitrequest is low (or the
// optional timeout expires), then pulse the response for one cycle in RESP.
// RESP also guarantees the strobes are low for a cycle between accesses.
module mips_cpu_mem_master
  import mips_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic [3:0]  byteenable,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  // A strobe may stay high for at most TIMEOUT_CYCLES cycles; the abort fires
  // on the stalled edge that ends the last permitted cycle.
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  mem_state_t  state_q, state_d;
  logic        wr_q;
  logic        signed_q;
  mem_size_t   size_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [31:0] cnt_q;
  logic        err_q;

  logic        accept;
  logic        done_ok;
  logic        timeout_hit;
  mem_size_t   req_sz;
  logic        req_bad;

  mem_size_t   al_size;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign req_sz  = mem_size_t'(req_size);
  assign req_bad = (req_sz == SZ_BAD) || misaligned(req_sz, req_addr[1:0]);

  // In IDLE the aligner works on the incoming request (lanes to latch);
  // afterwards it works on the latched request (load extension).
  assign al_size = (state_q == IDLE) ? req_sz : size_q;
  assign al_off  = (state_q == IDLE) ? req_addr[1:0] : off_q;

  mips_mem_lane_align u_align (
    .size_i   (al_size),
    .offset_i (al_off),
    .signed_i (signed_q),
    .wdata_i  (req_wdata),
    .rdata_i  (readdata),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

  assign address    = addr_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

  // State register; reset drops the strobes immediately since they decode the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state decode and the handshake/strobe outputs.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    read        = 1'b0;
    write       = 1'b0;
    resp_valid  = 1'b0;
    accept      = 1'b0;
    done_ok     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = req_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        read  = ~wr_q;
        write = wr_q;
        if (!waitrequest) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          timeout_hit = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch at accept, stall counting and result capture during ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too because they drive bus and response ports that must read zero out of reset.
      wr_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      off_q    <= 2'b00;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      wr_q     <= req_write;
      signed_q <= req_signed;
      size_q   <= req_sz;
      off_q    <= req_addr[1:0];
      addr_q   <= {req_addr[31:2], 2'b00};
      be_q     <= al_be;
      wdata_q  <= al_wdata;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= req_bad;
    end else if (state_q == ACCESS) begin
      if (done_ok) begin
        rdata_q <= wr_q ? 32'd0 : al_rdata;
      end else begin
        cnt_q <= cnt_q + 32'd1;
        err_q <= timeout_hit;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_mem_master.sv
// Self-checking bench: Avalon slave with programmable wait count, directed
// cases followed by randomized requests checked against an arithmetic model.
module tb_mips_cpu_mem_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model: stalls the first slv_wait edges of each strobe burst.
  int slv_wait = 0;
  int hi_cnt   = 0;

  mips_cpu_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err),
    .resp_rdata  (resp_rdata),
    .address     (address),
    .byteenable  (byteenable),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  assign waitrequest = (read || write) && (hi_cnt < slv_wait);

  always @(posedge clk) begin
    if (read || write) begin
      if (waitrequest) hi_cnt <= hi_cnt + 1;
    end else begin
      hi_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request, called at a falling edge. hold keeps req_valid high afterwards.
  task automatic txn(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int w, input bit hold);
    int        o;
    bit        bad;
    bit        tmo;
    int        exp_lat, exp_strobe;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, v;
    int        guard, lat, rcnt, wcnt, unstable;
    bit        done, first, strobe_in_resp;
    logic [31:0] got_addr, got_wd, got_rd;
    logic [3:0]  got_be;
    logic        got_err;

    // Reference model
    o   = int'(a[1:0]);
    bad = (sz == 2'd3) || (sz == 2'd1 && (o % 2) != 0) || (sz == 2'd2 && o != 0);
    tmo = !bad && (w >= TO);
    exp_be = 4'b0; exp_wd = 32'd0; exp_rd = 32'd0;
    case (sz)
      2'd0: begin
        exp_be = 4'(1 << o);
        exp_wd = (wd & 32'hFF) * 32'h0101_0101;
        v = (rd >> (8 * o)) & 32'hFF;
        if (sg && v >= 32'd128) v = v - 32'd256;
        exp_rd = v;
      end
      2'd1: begin
        exp_be = (o >= 2) ? 4'b1100 : 4'b0011;
        exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
        v = (rd >> (16 * (o / 2))) & 32'hFFFF;
        if (sg && v >= 32'd32768) v = v - 32'd65536;
        exp_rd = v;
      end
      default: begin
        exp_be = 4'b1111;
        exp_wd = wd;
        exp_rd = rd;
      end
    endcase
    if (bad)      begin exp_lat = 1;     exp_strobe = 0;  end
    else if (tmo) begin exp_lat = TO + 1; exp_strobe = TO; end
    else          begin exp_lat = w + 2; exp_strobe = w + 1; end
    if (bad || tmo || wr) exp_rd = 32'd0;

    // Drive request
    slv_wait   = w;
    readdata   = rd;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_at_accept", 32'(req_ready), 32'd1);

    // Monitor until the response pulse
    done = 0; first = 1; lat = 0; rcnt = 0; wcnt = 0; unstable = 0; strobe_in_resp = 0;
    got_addr = '0; got_wd = '0; got_be = '0; got_rd = '0; got_err = 1'b0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) req_valid = 1'b0;
      if (read || write) begin
        rcnt += int'(read);
        wcnt += int'(write);
        if (first) begin
          got_addr = address; got_be = byteenable; got_wd = writedata; first = 0;
        end else if (address !== got_addr || byteenable !== got_be || writedata !== got_wd) begin
          unstable++;
        end
      end
      if (resp_valid) begin
        done = 1; lat = k; got_err = resp_err; got_rd = resp_rdata;
        strobe_in_resp = read || write;
      end
    end
    check("resp_seen", 32'(done), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("read_cycles", 32'(rcnt), (wr ? 32'd0 : 32'(exp_strobe)));
    check("write_cycles", 32'(wcnt), (wr ? 32'(exp_strobe) : 32'd0));
    check("strobe_low_in_resp", 32'(strobe_in_resp), 32'd0);
    check("resp_err", 32'(got_err), 32'(bad || tmo));
    check("resp_rdata", got_rd, exp_rd);
    if (exp_strobe > 0) begin
      check("address", got_addr, {a[31:2], 2'b00});
      check("byteenable", 32'(got_be), 32'(exp_be));
      if (wr) check("writedata", got_wd, exp_wd);
      check("bus_stable", 32'(unstable), 32'd0);
    end

    // Response lasts exactly one cycle and the master is ready again
    @(negedge clk);
    check("resp_pulse", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_strobes", {30'd0, read, write}, 32'd0);
    check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_be", 32'(byteenable), 32'd0);
    check("rst_wdata", writedata, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    txn(1'b1, 2'b10, 1'b0, 32'hBFC0_0004, 32'hDEAD_BEEF, 32'h0, 3, 0);  // sw, 3 waits
    txn(1'b0, 2'b00, 1'b1, 32'hBFC0_0003, 32'h0, 32'h8011_2233, 0, 0);  // lb
    txn(1'b0, 2'b00, 1'b0, 32'hBFC0_0003, 32'h0, 32'h8011_2233, 0, 0);  // lbu
    txn(1'b1, 2'b01, 1'b0, 32'hBFC0_0012, 32'h0000_ABCD, 32'h0, 1, 0);  // sh
    txn(1'b0, 2'b01, 1'b1, 32'hBFC0_0002, 32'h0, 32'h8001_7FFF, 0, 0);  // lh upper half
    txn(1'b0, 2'b10, 1'b0, 32'hBFC0_0001, 32'h0, 32'h1234_5678, 0, 0);  // misaligned lw
    txn(1'b0, 2'b11, 1'b0, 32'hBFC0_0000, 32'h0, 32'h1234_5678, 0, 0);  // invalid size
    txn(1'b0, 2'b10, 1'b0, 32'hBFC0_0020, 32'h0, 32'hCAFE_F00D, 0, 1);  // back-to-back lw
    txn(1'b0, 2'b10, 1'b0, 32'hBFC0_0024, 32'h0, 32'h0BAD_C0DE, 0, 0);

    // Reset in the middle of a stalled read
    slv_wait  = 100;
    req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr  = 32'hBFC0_0040; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_read_high", {30'd0, read, waitrequest}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("async_read_drop", 32'(read), 32'd0);
    check("async_ready", 32'(req_ready), 32'd1);
    check("async_address", address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    check("idle_after_reset", {30'd0, read, write}, 32'd0);

    // Stuck slave hits the timeout
    txn(1'b0, 2'b10, 1'b0, 32'hBFC0_0050, 32'h0, 32'h1111_2222, 100, 0);
    txn(1'b1, 2'b00, 1'b0, 32'hBFC0_0051, 32'h0000_00A5, 32'h0, 100, 0);

    // Randomized requests
    for (int i = 0; i < 60; i++) begin
      int r;
      logic [1:0] sz;
      r  = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
          $urandom, int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
